// File: rtl/aer_synapse_router.sv
// AER event consumer: queues source addresses, walks each source's weight row into
// saturating per-target accumulators, and publishes/clears them on every STEP tick.
module aer_synapse_router #(
  parameter int unsigned NEURON_ADR = 8,
  parameter int unsigned NEURON_NUM = 8,
  parameter int unsigned WEIGHT_W   = 8,
  parameter int unsigned CURRENT_W  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                EN_NEURON,
  input  logic [NEURON_ADR:0]                 ADDR,
  input  logic                                W_WE,
  input  logic [NEURON_ADR:0]                 W_SRC,
  input  logic [NEURON_ADR:0]                 W_DST,
  input  logic [WEIGHT_W-1:0]                 W_DATA,
  input  logic                                STEP,
  output logic [(NEURON_NUM+1)*CURRENT_W-1:0] I_SYN,
  output logic                                I_VALID,
  output logic                                BUSY,
  output logic                                DROP
);

  localparam int unsigned AW = NEURON_ADR + 1;
  localparam int unsigned NN = NEURON_NUM + 1;
  localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CURRENT_W + 1;
  localparam logic signed [CURRENT_W-1:0] CMAX = {1'b0, {(CURRENT_W-1){1'b1}}};
  localparam logic signed [CURRENT_W-1:0] CMIN = {1'b1, {(CURRENT_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                      state, state_nxt;
  logic [IW-1:0]               fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic [IW-1:0]               src, j;
  logic signed [WEIGHT_W-1:0]  w_mem [NN][NN];
  logic signed [CURRENT_W-1:0] acc [NN];
  logic signed [WEIGHT_W-1:0]  w_cur;
  logic                        addr_ok, push_req, full, push, pop, acc_en, wr_ok;

  // Two's-complement add with clamp instead of wrap.
  function automatic logic signed [CURRENT_W-1:0] sat_add(
    input logic signed [CURRENT_W-1:0] a,
    input logic signed [WEIGHT_W-1:0]  b
  );
    logic signed [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s[SW-1] != s[SW-2]) return s[SW-1] ? CMIN : CMAX;
    return s[CURRENT_W-1:0];
  endfunction

  assign addr_ok  = (ADDR != '1) && (ADDR <= AW'(NEURON_NUM));
  assign push_req = EN_NEURON && addr_ok;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push     = push_req && !full;
  assign wr_ok    = W_WE && (W_SRC <= AW'(NEURON_NUM)) && (W_DST <= AW'(NEURON_NUM));
  assign w_cur    = w_mem[src][j];
  assign BUSY     = (count != '0) || (state == S_ACCUM);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    acc_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_en = 1'b1;
        if (j == IW'(NEURON_NUM)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Event FIFO; fullness is judged before any same-cycle pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      DROP   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= IW'(ADDR);
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (push_req && full) DROP <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      src <= '0;
      j   <= '0;
    end else if (pop) begin
      src <= fifo_mem[rd_ptr];
      j   <= '0;
    end else if (acc_en) begin
      j   <= j + IW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < NN; s++)
        for (int d = 0; d < NN; d++) w_mem[s][d] <= '0;
    end else if (wr_ok) begin
      w_mem[IW'(W_SRC)][IW'(W_DST)] <= W_DATA;
    end
  end

  // An add landing in a STEP cycle seeds the fresh window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < NN; n++) acc[n] <= '0;
    end else begin
      if (STEP)
        for (int n = 0; n < NN; n++) acc[n] <= '0;
      if (acc_en)
        acc[j] <= STEP ? CURRENT_W'(w_cur) : sat_add(acc[j], w_cur);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      I_SYN   <= '0;
      I_VALID <= 1'b0;
    end else begin
      I_VALID <= STEP;
      if (STEP)
        for (int n = 0; n < NN; n++) I_SYN[n*CURRENT_W +: CURRENT_W] <= acc[n];
    end
  end

endmodule

// File: tb/tb_aer_synapse_router.sv
// Scoreboard bench for aer_synapse_router: expected current vectors are queued at each
// STEP and compared when I_VALID appears.
module tb_aer_synapse_router;

  localparam int unsigned NA  = 8;
  localparam int unsigned NMX = 8;
  localparam int unsigned NN  = 9;
  localparam int unsigned WW  = 8;
  localparam int unsigned CWI = 16;
  localparam int unsigned FD  = 4;
  localparam int unsigned VW  = NN * CWI;

  logic          CLK, RST, EN_NEURON, W_WE, STEP;
  logic [NA:0]   ADDR, W_SRC, W_DST;
  logic [WW-1:0] W_DATA;
  logic [VW-1:0] I_SYN;
  logic          I_VALID, BUSY, DROP;

  int checks, failures, cyc;
  int mdl [NN];
  int wt  [NN][NN];
  logic [VW-1:0] exp_q [$];
  logic [VW-1:0] mon_exp;

  aer_synapse_router #(
    .NEURON_ADR(NA), .NEURON_NUM(NMX), .WEIGHT_W(WW), .CURRENT_W(CWI), .FIFO_DEPTH(FD)
  ) dut (
    .CLK(CLK), .RST(RST), .EN_NEURON(EN_NEURON), .ADDR(ADDR),
    .W_WE(W_WE), .W_SRC(W_SRC), .W_DST(W_DST), .W_DATA(W_DATA),
    .STEP(STEP), .I_SYN(I_SYN), .I_VALID(I_VALID), .BUSY(BUSY), .DROP(DROP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every published vector must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && I_VALID === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL i_syn_unexpected: I_VALID with empty scoreboard, I_SYN=%h", I_SYN);
      end else begin
        mon_exp = exp_q.pop_front();
        if (I_SYN !== mon_exp) begin
          failures++;
          $display("FAIL i_syn: got %h expected %h", I_SYN, mon_exp);
        end
      end
    end
  end

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic do_reset();
    RST = 1'b1; EN_NEURON = 1'b0; W_WE = 1'b0; STEP = 1'b0;
    ADDR = '1; W_SRC = '0; W_DST = '0; W_DATA = '0;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    for (int n = 0; n < NN; n++) begin
      mdl[n] = 0;
      for (int d = 0; d < NN; d++) wt[n][d] = 0;
    end
  endtask

  task automatic wr_weight(input int s, input int d, input int v);
    W_WE = 1'b1; W_SRC = s[NA:0]; W_DST = d[NA:0]; W_DATA = v[WW-1:0];
    @(negedge CLK);
    W_WE = 1'b0;
    if (s < NN && d < NN) wt[s][d] = v;
  endtask

  task automatic send_event(input int a, input bit upd);
    EN_NEURON = 1'b1; ADDR = a[NA:0];
    @(negedge CLK);
    EN_NEURON = 1'b0; ADDR = '1;
    if (upd)
      for (int t = 0; t < NN; t++) mdl[t] = sat16(mdl[t] + wt[a][t]);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (BUSY === 1'b0) begin done = 1'b1; break; end
      @(negedge CLK);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_idle_timeout: BUSY=%b after %0d cycles, required 0", tag, BUSY, bound);
    end
  endtask

  task automatic do_step(input string tag);
    logic [VW-1:0] v;
    for (int n = 0; n < NN; n++) begin
      v[n*CWI +: CWI] = CWI'(mdl[n]);
      mdl[n] = 0;
    end
    exp_q.push_back(v);
    STEP = 1'b1;
    @(negedge CLK);
    STEP = 1'b0;
    checks++;
    if (I_VALID !== 1'b1) begin
      failures++; $display("FAIL %s_valid_rise: I_VALID=%b required 1", tag, I_VALID);
    end
    @(negedge CLK);
    checks++;
    if (I_VALID !== 1'b0) begin
      failures++; $display("FAIL %s_valid_pulse: I_VALID=%b required 0", tag, I_VALID);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (I_SYN !== '0)     begin failures++; $display("FAIL reset_i_syn: got %h required 0", I_SYN); end
    if (I_VALID !== 1'b0) begin failures++; $display("FAIL reset_i_valid: got %b required 0", I_VALID); end
    if (BUSY !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b required 0", BUSY); end
    if (DROP !== 1'b0)    begin failures++; $display("FAIL reset_drop: got %b required 0", DROP); end
  endtask

  task automatic test_single_event();
    wr_weight(2, 5, 10);
    send_event(2, 1'b1);
    checks++;
    if (BUSY !== 1'b1) begin failures++; $display("FAIL single_busy: got %b required 1", BUSY); end
    wait_idle(50, "single");
    do_step("single");
  endtask

  task automatic test_saturation();
    wr_weight(3, 0, 127);
    for (int i = 0; i < 300; i++) begin
      send_event(3, 1'b1);
      wait_idle(20, "sat_pos");
    end
    do_step("sat_pos");
    wr_weight(3, 0, -128);
    for (int i = 0; i < 300; i++) begin
      send_event(3, 1'b1);
      wait_idle(20, "sat_neg");
    end
    do_step("sat_neg");
    checks++;
    if (DROP !== 1'b0) begin failures++; $display("FAIL sat_drop: got %b required 0", DROP); end
  endtask

  task automatic test_back_to_back();
    int t0, elapsed;
    do_reset();
    for (int t = 0; t < NN; t++) wr_weight(1, t, 1);
    send_event(0, 1'b1);           // zero-weight row keeps the FSM busy during the burst
    t0 = cyc;
    @(negedge CLK);
    for (int i = 0; i < FD; i++) send_event(1, 1'b1);
    checks++;
    if (DROP !== 1'b0) begin failures++; $display("FAIL b2b_drop_early: got %b required 0", DROP); end
    send_event(1, 1'b0);
    checks += 2;
    if (DROP !== 1'b1) begin failures++; $display("FAIL b2b_drop: got %b required 1", DROP); end
    if (BUSY !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b required 1", BUSY); end
    wait_idle(200, "b2b");
    elapsed = cyc - t0;
    checks++;
    if (elapsed != 5 * (NMX + 2)) begin
      failures++; $display("FAIL b2b_busy_fall: BUSY fell %0d cycles after first event, required %0d", elapsed, 5 * (NMX + 2));
    end
    do_step("b2b");
    checks++;
    if (DROP !== 1'b1) begin failures++; $display("FAIL b2b_drop_sticky: got %b required 1", DROP); end
  endtask

  task automatic test_invalid_addr();
    do_reset();
    wr_weight(0, 0, 33);
    wr_weight(9, 0, 50);
    wr_weight(0, 9, 50);
    send_event(9'h1FF, 1'b0);
    checks += 2;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL inv_ones_busy: got %b required 0", BUSY); end
    if (DROP !== 1'b0) begin failures++; $display("FAIL inv_ones_drop: got %b required 0", DROP); end
    send_event(9, 1'b0);
    checks += 2;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL inv_range_busy: got %b required 0", BUSY); end
    if (DROP !== 1'b0) begin failures++; $display("FAIL inv_range_drop: got %b required 0", DROP); end
    send_event(0, 1'b1);
    wait_idle(50, "inv");
    do_step("inv");
  endtask

  task automatic test_step_straddle();
    do_reset();
    wr_weight(6, 3, 2);
    wr_weight(6, 4, 7);
    wr_weight(6, 5, 3);
    send_event(6, 1'b0);           // sampled at edge k; target t lands at edge k+2+t
    repeat (5) @(negedge CLK);
    mdl[3] = 2;
    do_step("straddle_a");         // STEP sampled at edge k+6, same edge as target 4
    mdl[4] = 7;
    mdl[5] = 3;
    wait_idle(50, "straddle");
    do_step("straddle_b");
  endtask

  task automatic test_reset_mid_accum();
    do_reset();
    wr_weight(2, 0, 5);
    send_event(2, 1'b1);
    wait_idle(50, "rst_prep");
    do_step("rst_prep");
    for (int i = 0; i < FD + 2; i++) send_event(2, 1'b0);
    checks++;
    if (DROP !== 1'b1) begin failures++; $display("FAIL rst_drop_set: got %b required 1", DROP); end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int n = 0; n < NN; n++) begin
      mdl[n] = 0;
      for (int d = 0; d < NN; d++) wt[n][d] = 0;
    end
    checks += 4;
    if (BUSY !== 1'b0)    begin failures++; $display("FAIL rst_busy: got %b required 0", BUSY); end
    if (I_SYN !== '0)     begin failures++; $display("FAIL rst_i_syn: got %h required 0", I_SYN); end
    if (DROP !== 1'b0)    begin failures++; $display("FAIL rst_drop: got %b required 0", DROP); end
    if (I_VALID !== 1'b0) begin failures++; $display("FAIL rst_i_valid: got %b required 0", I_VALID); end
    repeat (30) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_stays_idle: got %b required 0", BUSY); end
    do_step("rst_zero");
    send_event(2, 1'b1);
    wait_idle(50, "rst_wclr");
    do_step("rst_wclr");
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    test_reset();
    test_single_event();
    test_saturation();
    test_back_to_back();
    test_invalid_addr();
    test_step_straddle();
    test_reset_mid_accum();
    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d expected vectors never published, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
